spi_master_ctrl: RTL and testbench

SPI_MASTER_CTRL -- requirements
Module: spi_master_ctrl

---
 rtl/spi_master_ctrl_if.sv | 30 +++
 rtl/spi_master_ctrl.sv | 138 +++++++++++++
 tb/tb_spi_master_ctrl.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_master_ctrl_if.sv
// Bus bundle for spi_master_ctrl: requester handshake, configuration,
// received data and the SPI pins. The master modport is the controller side.
interface spi_master_ctrl_if #(
    parameter int DW  = 8,
    parameter int CDW = 8
);
    logic [1:0]     REQ;
    logic [DW-1:0]  TX_DATA0;
    logic [DW-1:0]  TX_DATA1;
    logic [1:0]     MODE;
    logic [CDW-1:0] CLK_DIV;
    logic [1:0]     GNT;
    logic [1:0]     DONE;
    logic [DW-1:0]  RX_DATA;
    logic           BUSY;
    logic           SCK;
    logic           MOSI;
    logic [1:0]     SS;
    logic           MISO;

    modport master (
        input  REQ, TX_DATA0, TX_DATA1, MODE, CLK_DIV, MISO,
        output GNT, DONE, RX_DATA, BUSY, SCK, MOSI, SS
    );

    modport slave (
        output REQ, TX_DATA0, TX_DATA1, MODE, CLK_DIV, MISO,
        input  GNT, DONE, RX_DATA, BUSY, SCK, MOSI, SS
    );
endinterface

// File: rtl/spi_master_ctrl.sv
// Two-requester SPI master with round-robin arbitration. Mode, divider and
// TX frame are captured at grant so a frame is immune to later input changes.
//
// state | meaning
// IDLE  | SS high, SCK tracks CPOL, waiting for a request
// SETUP | slave selected, first half-period before edge 1
// XFER  | generating SCK edges 2..2*DW, shifting data
// HOLD  | final half-period with SCK at CPOL before SS release
module spi_master_ctrl #(
    parameter int DW  = 8,
    parameter int CDW = 8
) (
    input  logic             PCLK,
    input  logic             PRESETn,
    spi_master_ctrl_if.master bus
);
    localparam int EW = $clog2(2*DW+1);
    localparam logic [EW-1:0] LAST_EDGE = EW'(2*DW);

    typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;

    state_t         state;
    logic [CDW-1:0] cnt;
    logic [CDW-1:0] div_q;
    logic [EW-1:0]  ecnt;
    logic [EW-1:0]  edge_n;
    logic           cpha_q;
    logic           last_q;
    logic           sel_q;
    logic           win;
    logic [DW-1:0]  tx_sel;
    logic [DW-1:0]  tx_q;
    logic [DW-1:0]  rx_q;
    logic [1:0]     gnt_q;
    logic [1:0]     done_q;
    logic [DW-1:0]  rx_data_q;
    logic           sck_q;
    logic           mosi_q;
    logic [1:0]     ss_q;

    // Round-robin pick: on a tie the requester not served last wins.
    always_comb begin
        win = 1'b0;
        case (bus.REQ)
            2'b01:   win = 1'b0;
            2'b10:   win = 1'b1;
            2'b11:   win = ~last_q;
            default: win = 1'b0;
        endcase
        tx_sel = win ? bus.TX_DATA1 : bus.TX_DATA0;
        edge_n = ecnt + EW'(1);
    end

    // Sequencer: arbitration, half-period down-counter, SCK edges and shifting.
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state     <= IDLE;
            cnt       <= '0;
            div_q     <= '0;
            ecnt      <= '0;
            cpha_q    <= 1'b0;
            last_q    <= 1'b1;
            sel_q     <= 1'b0;
            tx_q      <= '0;
            rx_q      <= '0;
            gnt_q     <= 2'b00;
            done_q    <= 2'b00;
            rx_data_q <= '0;
            sck_q     <= 1'b0;
            mosi_q    <= 1'b0;
            ss_q      <= 2'b11;
        end else begin
            gnt_q  <= 2'b00;
            done_q <= 2'b00;
            case (state)
                IDLE: begin
                    sck_q  <= bus.MODE[1];
                    mosi_q <= 1'b0;
                    if (bus.REQ != 2'b00) begin
                        state  <= SETUP;
                        sel_q  <= win;
                        last_q <= win;
                        gnt_q  <= win ? 2'b10 : 2'b01;
                        ss_q   <= win ? 2'b01 : 2'b10;
                        cpha_q <= bus.MODE[0];
                        div_q  <= bus.CLK_DIV;
                        cnt    <= bus.CLK_DIV;
                        ecnt   <= '0;
                        rx_q   <= '0;
                        // CPHA=0 drives the MSB as soon as SS falls.
                        if (bus.MODE[0]) begin
                            tx_q <= tx_sel;
                        end else begin
                            mosi_q <= tx_sel[DW-1];
                            tx_q   <= tx_sel << 1;
                        end
                    end
                end
                SETUP, XFER: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CDW'(1);
                    end else begin
                        cnt   <= div_q;
                        sck_q <= ~sck_q;
                        ecnt  <= edge_n;
                        state <= (edge_n == LAST_EDGE) ? HOLD : XFER;
                        if (edge_n[0] ^ cpha_q) begin
                            rx_q <= {rx_q[DW-2:0], bus.MISO};
                        end else if (edge_n != LAST_EDGE) begin
                            mosi_q <= tx_q[DW-1];
                            tx_q   <= tx_q << 1;
                        end
                    end
                end
                HOLD: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CDW'(1);
                    end else begin
                        state     <= IDLE;
                        ss_q      <= 2'b11;
                        mosi_q    <= 1'b0;
                        rx_data_q <= rx_q;
                        done_q    <= sel_q ? 2'b10 : 2'b01;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.GNT     = gnt_q;
    assign bus.DONE    = done_q;
    assign bus.RX_DATA = rx_data_q;
    assign bus.BUSY    = (state != IDLE);
    assign bus.SCK     = sck_q;
    assign bus.MOSI    = mosi_q;
    assign bus.SS      = ss_q;
endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl: loopback and a CPHA=1 slave model,
// with a bus monitor measuring SS low time, SCK edge spacing and MOSI bits.
module tb_spi_master_ctrl;
    localparam int DW  = 8;
    localparam int CDW = 8;

    logic PCLK    = 1'b0;
    logic PRESETn = 1'b0;
    always #5 PCLK = ~PCLK;

    spi_master_ctrl_if #(.DW(DW), .CDW(CDW)) bus();
    spi_master_ctrl #(.DW(DW), .CDW(CDW)) dut (.PCLK(PCLK), .PRESETn(PRESETn), .bus(bus));

    int checks   = 0;
    int failures = 0;

    logic       loopback  = 1'b1;
    logic       slave_bit = 1'b0;
    logic [7:0] sl_sh     = 8'h00;
    int         sl_edges  = 0;
    assign bus.MISO = loopback ? bus.MOSI : slave_bit;

    // monitor state
    int         cyc = 0;
    logic [1:0] prev_ss = 2'b11;
    logic       prev_sck = 1'b0;
    int         run = 0, edges = 0, last_stamp = 0, spacing_err = 0, both_low = 0, done_cnt = 0;
    int         h_exp = 1;
    logic       mon_cpha = 1'b0;
    logic [1:0] who = 2'b00;
    logic [7:0] mosi_cap = 8'h00;
    int         frame_len[$];
    int         frame_edges[$];
    logic [1:0] frame_who[$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge PCLK) cyc <= cyc + 1;

    // CPHA=1 slave: drive next bit on each odd (leading) edge
    always @(bus.SCK) begin
        if (bus.SS != 2'b11) begin
            sl_edges++;
            if (sl_edges % 2 == 1) begin
                slave_bit = sl_sh[7];
                sl_sh     = sl_sh << 1;
            end
        end
    end

    always @(negedge PCLK) begin
        if (bus.SS == 2'b00) both_low++;
        if (bus.DONE != 2'b00) done_cnt++;
        if (bus.SS != 2'b11) begin
            if (prev_ss == 2'b11) begin
                run = 0; edges = 0; last_stamp = cyc; who = ~bus.SS; mosi_cap = 8'h00;
            end
            run++;
            if (bus.SCK != prev_sck) begin
                edges++;
                if (cyc - last_stamp != h_exp) spacing_err++;
                last_stamp = cyc;
                if ((edges % 2 == 1) != mon_cpha) mosi_cap = {mosi_cap[6:0], bus.MOSI};
            end
        end else if (prev_ss != 2'b11) begin
            frame_len.push_back(run);
            frame_edges.push_back(edges);
            frame_who.push_back(who);
        end
        prev_ss  = bus.SS;
        prev_sck = bus.SCK;
    end

    task automatic clear_mon();
        spacing_err = 0; both_low = 0; done_cnt = 0;
        frame_len.delete(); frame_edges.delete(); frame_who.delete();
    endtask

    task automatic wait_gnt(output logic [1:0] g);
        g = 2'b00;
        for (int i = 0; i < 100; i++) begin
            @(negedge PCLK);
            if (bus.GNT != 2'b00) begin g = bus.GNT; break; end
        end
    endtask

    task automatic wait_done(output logic [1:0] d, output logic [7:0] rx);
        d = 2'b00; rx = 8'h00;
        for (int i = 0; i < 10000; i++) begin
            @(negedge PCLK);
            if (bus.DONE != 2'b00) begin d = bus.DONE; rx = bus.RX_DATA; break; end
        end
    endtask

    task automatic run_frame(input logic [1:0] req, output logic [1:0] g,
                             output logic [1:0] d, output logic [7:0] rx);
        bus.REQ = req;
        wait_gnt(g);
        bus.REQ = 2'b00;
        wait_done(d, rx);
        repeat (2) @(negedge PCLK);
    endtask

    task automatic check_frame(input string tag, input int len, input logic [1:0] w);
        check_val({tag, "_nframes"}, frame_len.size(), 1);
        for (int i = 0; i < frame_len.size(); i++) begin
            check_val({tag, "_ss_low"}, frame_len[i], len);
            check_val({tag, "_edges"}, frame_edges[i], 16);
            check_val({tag, "_ss_who"}, frame_who[i], w);
        end
        check_val({tag, "_spacing"}, spacing_err, 0);
    endtask

    logic [1:0] g, d;
    logic [7:0] rx;
    logic [1:0] glog[3];
    logic [7:0] rxlog[3];
    int gcount, dcount;

    initial begin
        bus.REQ = 2'b00; bus.TX_DATA0 = 8'h00; bus.TX_DATA1 = 8'h00;
        bus.MODE = 2'b11; bus.CLK_DIV = 8'h00;

        // reset values, SCK low even with CPOL=1 requested
        repeat (3) @(negedge PCLK);
        check_val("rst_ss", bus.SS, 2'b11);
        check_val("rst_sck", bus.SCK, 1'b0);
        check_val("rst_mosi", bus.MOSI, 1'b0);
        check_val("rst_gnt", bus.GNT, 2'b00);
        check_val("rst_done", bus.DONE, 2'b00);
        check_val("rst_rx", bus.RX_DATA, 8'h00);
        check_val("rst_busy", bus.BUSY, 1'b0);
        bus.MODE = 2'b00;
        PRESETn = 1'b1;
        repeat (2) @(negedge PCLK);

        // mode 0, H=1, loopback 0xA5
        loopback = 1'b1; mon_cpha = 1'b0; h_exp = 1;
        bus.TX_DATA0 = 8'hA5;
        clear_mon();
        bus.REQ = 2'b01;
        wait_gnt(g);
        bus.REQ = 2'b00;
        check_val("t1_gnt", g, 2'b01);
        check_val("t1_mosi_msb", bus.MOSI, 1'b1);
        @(negedge PCLK);
        check_val("t1_gnt_pulse", bus.GNT, 2'b00);
        check_val("t1_busy", bus.BUSY, 1'b1);
        wait_done(d, rx);
        check_val("t1_done", d, 2'b01);
        check_val("t1_rx", rx, 8'hA5);
        @(negedge PCLK);
        check_val("t1_done_pulse", bus.DONE, 2'b00);
        @(negedge PCLK);
        check_frame("t1", 17, 2'b01);
        check_val("t1_mosi_bits", mosi_cap, 8'hA5);
        check_val("t1_sck_idle", bus.SCK, 1'b0);

        // reset pointer back to 0, then three tied frames
        PRESETn = 1'b0; @(negedge PCLK); PRESETn = 1'b1; @(negedge PCLK);
        h_exp = 2; bus.CLK_DIV = 8'd1;
        bus.TX_DATA0 = 8'h3C; bus.TX_DATA1 = 8'h81;
        clear_mon();
        gcount = 0; dcount = 0;
        bus.REQ = 2'b11;
        for (int c = 0; c < 2000 && dcount < 3; c++) begin
            @(negedge PCLK);
            if (bus.GNT != 2'b00) begin
                if (gcount < 3) glog[gcount] = bus.GNT;
                gcount++;
                if (gcount == 3) bus.REQ = 2'b00;
            end
            if (bus.DONE != 2'b00) begin
                if (dcount < 3) rxlog[dcount] = bus.RX_DATA;
                dcount++;
            end
        end
        bus.REQ = 2'b00;
        repeat (2) @(negedge PCLK);
        check_val("t3_ndone", dcount, 3);
        check_val("t3_gnt0", glog[0], 2'b01);
        check_val("t3_gnt1", glog[1], 2'b10);
        check_val("t3_gnt2", glog[2], 2'b01);
        check_val("t3_rx1", rxlog[1], 8'h81);
        check_val("t3_rx2", rxlog[2], 8'h3C);
        check_val("t3_both_low", both_low, 0);
        check_val("t3_nframes", frame_len.size(), 3);
        foreach (frame_len[i]) check_val("t3_ss_low", frame_len[i], 34);

        // mode 3, H=4, slave returns 0xC3
        loopback = 1'b0; mon_cpha = 1'b1; h_exp = 4;
        bus.MODE = 2'b11; bus.CLK_DIV = 8'd3; bus.TX_DATA1 = 8'h5A;
        sl_sh = 8'hC3; sl_edges = 0;
        repeat (3) @(negedge PCLK);
        check_val("t2_sck_idle_hi", bus.SCK, 1'b1);
        clear_mon();
        run_frame(2'b10, g, d, rx);
        check_val("t2_gnt", g, 2'b10);
        check_val("t2_done", d, 2'b10);
        check_val("t2_rx", rx, 8'hC3);
        check_frame("t2", 68, 2'b10);
        check_val("t2_mosi_bits", mosi_cap, 8'h5A);
        check_val("t2_sck_end", bus.SCK, 1'b1);

        // config change mid-frame uses latched values
        loopback = 1'b1; mon_cpha = 1'b0; h_exp = 1;
        bus.MODE = 2'b00; bus.CLK_DIV = 8'd0; bus.TX_DATA0 = 8'h96;
        repeat (2) @(negedge PCLK);
        clear_mon();
        bus.REQ = 2'b01;
        wait_gnt(g);
        bus.REQ = 2'b00;
        repeat (5) @(negedge PCLK);
        bus.MODE = 2'b01; bus.TX_DATA0 = 8'h0F;
        wait_done(d, rx);
        repeat (2) @(negedge PCLK);
        check_val("t4a_rx", rx, 8'h96);
        check_val("t4a_mosi_bits", mosi_cap, 8'h96);
        check_frame("t4a", 17, 2'b01);
        mon_cpha = 1'b1;
        clear_mon();
        run_frame(2'b01, g, d, rx);
        check_val("t4b_rx", rx, 8'h0F);
        check_val("t4b_mosi_bits", mosi_cap, 8'h0F);
        check_frame("t4b", 17, 2'b01);

        // reset at edge 7 aborts the frame
        mon_cpha = 1'b0; h_exp = 4;
        bus.MODE = 2'b00; bus.CLK_DIV = 8'd3; bus.TX_DATA0 = 8'hFF;
        repeat (2) @(negedge PCLK);
        clear_mon();
        bus.REQ = 2'b01;
        wait_gnt(g);
        bus.REQ = 2'b00;
        for (int c = 0; c < 200; c++) begin
            @(negedge PCLK);
            if (edges >= 6) break;
        end
        check_val("t5_reached_edge6", edges, 6);
        repeat (3) @(negedge PCLK);
        PRESETn = 1'b0;
        @(negedge PCLK);
        check_val("t5_ss", bus.SS, 2'b11);
        check_val("t5_sck", bus.SCK, 1'b0);
        check_val("t5_busy", bus.BUSY, 1'b0);
        check_val("t5_done", bus.DONE, 2'b00);
        check_val("t5_rx", bus.RX_DATA, 8'h00);
        PRESETn = 1'b1;
        repeat (100) @(negedge PCLK);
        check_val("t5_no_done", done_cnt, 0);
        h_exp = 1; bus.CLK_DIV = 8'd0; bus.TX_DATA1 = 8'h5A;
        clear_mon();
        run_frame(2'b10, g, d, rx);
        check_val("t5_gnt", g, 2'b10);
        check_val("t5_done_after", d, 2'b10);
        check_val("t5_rx_after", rx, 8'h5A);
        check_frame("t5", 17, 2'b10);

        // largest divider: H = 256
        h_exp = 256; bus.CLK_DIV = 8'hFF; bus.TX_DATA0 = 8'hE7;
        clear_mon();
        run_frame(2'b01, g, d, rx);
        check_val("t6_done", d, 2'b01);
        check_val("t6_rx", rx, 8'hE7);
        check_frame("t6", 17*256, 2'b01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
